// File: rtl/spwtcr_flow_credit.sv
// SpaceWire flow-control credit manager: RX/TX credit, FCT request handshake.
// Optional status ports enabled with `define SPWTCR_CREDIT_STATUS_EN.
module spwtcr_flow_credit #(
  parameter int CREDIT_W   = 7,
  parameter int FCT_CHUNK  = 8,
  parameter int MAX_CREDIT = 56,
  parameter int FREE_W     = 8
) (
  input  logic              CLOCK,
  input  logic              RESETn,
  input  logic              linkEnable,
  input  logic              gotNChar,
  input  logic [FREE_W-1:0] fifoFree,
  output logic              sendFctReq,
  input  logic              sendFctAck,
  input  logic              gotFct,
  input  logic              sentNChar,
  output logic              txCreditAvail,
  output logic              creditErrRx,
  output logic              creditErrTx
`ifdef SPWTCR_CREDIT_STATUS_EN
  ,
  output logic [CREDIT_W-1:0] rxCreditCnt,
  output logic [CREDIT_W-1:0] txCreditCnt,
  output logic [3:0]          errCause
`endif
);

  localparam int WW = ((CREDIT_W > FREE_W) ? CREDIT_W : FREE_W) + 1;
  localparam logic [WW-1:0] CHUNK = WW'(FCT_CHUNK);
  localparam logic [WW-1:0] MAXC  = WW'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] MAXC_CW = CREDIT_W'(MAX_CREDIT);

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  if (MAX_CREDIT >= (1 << CREDIT_W) || FCT_CHUNK > MAX_CREDIT) begin : g_param_chk
    $error("spwtcr_flow_credit: illegal MAX_CREDIT/FCT_CHUNK");
  end

  logic [1:0]          r_state;
  logic                r_en_dly;
  logic [CREDIT_W-1:0] r_rx;
  logic [CREDIT_W-1:0] r_tx;
  logic                r_err_rx;
  logic                r_err_tx;
  logic                r_tx_avail;

  logic                w_fall;
  logic [WW-1:0]       w_rx_w;
  logic [WW-1:0]       w_tx_w;
  logic [WW-1:0]       w_free;
  logic [WW-1:0]       w_rx_need;
  logic                w_req_ok;
  logic [1:0]          w_state_nx;

  logic [WW-1:0]       w_rx_add;
  logic                w_rx_un;
  logic                w_rx_dec;
  logic [WW-1:0]       w_rx_sum;
  logic                w_rx_ov;
  logic [CREDIT_W-1:0] w_rx_nx;

  logic                w_tx_un;
  logic                w_tx_dec;
  logic [WW-1:0]       w_tx_base;
  logic [WW-1:0]       w_tx_sum;
  logic                w_tx_ov;
  logic [WW-1:0]       w_tx_nx_w;

  assign w_fall    = r_en_dly & ~linkEnable;
  assign w_rx_w    = WW'(r_rx);
  assign w_tx_w    = WW'(r_tx);
  assign w_free    = WW'(fifoFree);
  assign w_rx_need = w_rx_w + CHUNK;

  // Grant only when the FIFO can really absorb all outstanding credit.
  assign w_req_ok = linkEnable & (w_rx_need <= MAXC)
                  & (w_free >= w_rx_need) & ~sendFctAck;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_WAIT:  if (w_req_ok) w_state_nx = S_REQ;
      S_REQ:   if (sendFctAck) w_state_nx = S_ACK;
      S_ACK:   w_state_nx = S_WAIT;
      default: w_state_nx = S_WAIT;
    endcase
    if (!linkEnable) w_state_nx = S_WAIT;
  end

  assign w_rx_add = (r_state == S_ACK) ? CHUNK : '0;
  assign w_rx_un  = gotNChar & (r_rx == '0);
  assign w_rx_dec = gotNChar & ~w_rx_un;
  assign w_rx_sum = w_rx_w + w_rx_add - WW'(w_rx_dec);
  assign w_rx_ov  = w_rx_sum > MAXC;
  assign w_rx_nx  = w_rx_ov ? MAXC_CW : w_rx_sum[CREDIT_W-1:0];

  // Decrement first so a same-cycle FCT is judged against the reduced credit.
  assign w_tx_un   = sentNChar & (r_tx == '0);
  assign w_tx_dec  = sentNChar & ~w_tx_un;
  assign w_tx_base = w_tx_w - WW'(w_tx_dec);
  assign w_tx_sum  = w_tx_base + CHUNK;
  assign w_tx_ov   = gotFct & (w_tx_sum > MAXC);
  assign w_tx_nx_w = (gotFct & ~w_tx_ov) ? w_tx_sum : w_tx_base;

  always_ff @(posedge CLOCK) begin
    if (!RESETn) begin
      r_state    <= S_WAIT;
      r_en_dly   <= 1'b0;
      r_rx       <= '0;
      r_tx       <= '0;
      r_err_rx   <= 1'b0;
      r_err_tx   <= 1'b0;
      r_tx_avail <= 1'b0;
    end else begin
      r_en_dly <= linkEnable;
      if (w_fall) begin
        r_state    <= S_WAIT;
        r_rx       <= '0;
        r_tx       <= '0;
        r_err_rx   <= 1'b0;
        r_err_tx   <= 1'b0;
        r_tx_avail <= 1'b0;
      end else begin
        r_state    <= w_state_nx;
        r_rx       <= w_rx_nx;
        r_tx       <= w_tx_nx_w[CREDIT_W-1:0];
        r_err_rx   <= w_rx_un | w_rx_ov;
        r_err_tx   <= w_tx_un | w_tx_ov;
        r_tx_avail <= (w_tx_nx_w != '0);
      end
    end
  end

  assign sendFctReq    = (r_state == S_REQ);
  assign txCreditAvail = r_tx_avail;
  assign creditErrRx   = r_err_rx;
  assign creditErrTx   = r_err_tx;

`ifdef SPWTCR_CREDIT_STATUS_EN
  logic [3:0] r_err_cause;

  always_ff @(posedge CLOCK) begin
    if (!RESETn) begin
      r_err_cause <= '0;
    end else if (w_fall) begin
      r_err_cause <= '0;
    end else begin
      r_err_cause <= r_err_cause
                   | {w_tx_ov, w_tx_un, w_rx_ov, w_rx_un};
    end
  end

  assign rxCreditCnt = r_rx;
  assign txCreditCnt = r_tx;
  assign errCause    = r_err_cause;
`endif

endmodule

// File: tb/tb_spwtcr_flow_credit.sv
// Bench for spwtcr_flow_credit: directed scenarios plus random traffic
// checked each cycle against an arithmetic credit model.
module tb_spwtcr_flow_credit;

  logic       CLOCK = 1'b0;
  logic       RESETn = 1'b0;
  logic       linkEnable = 1'b0;
  logic       gotNChar = 1'b0;
  logic [7:0] fifoFree = 8'd0;
  logic       sendFctAck = 1'b0;
  logic       gotFct = 1'b0;
  logic       sentNChar = 1'b0;
  logic       sendFctReq;
  logic       txCreditAvail;
  logic       creditErrRx;
  logic       creditErrTx;

  always #5 CLOCK = ~CLOCK;

  spwtcr_flow_credit dut (
    .CLOCK(CLOCK),
    .RESETn(RESETn),
    .linkEnable(linkEnable),
    .gotNChar(gotNChar),
    .fifoFree(fifoFree),
    .sendFctReq(sendFctReq),
    .sendFctAck(sendFctAck),
    .gotFct(gotFct),
    .sentNChar(sentNChar),
    .txCreditAvail(txCreditAvail),
    .creditErrRx(creditErrRx),
    .creditErrTx(creditErrTx)
  );

  int tests = 0;
  int fails = 0;

  int m_rx = 0;
  int m_tx = 0;
  bit m_req = 0;
  bit m_grant = 0;
  bit m_erx = 0;
  bit m_etx = 0;
  bit m_prev_en = 0;

  bit auto_ack = 0;
  int acks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Credit model: plain counters, a pending-request flag and a grant-due flag.
  task automatic model_step();
    bit fall;
    int n;
    int t;
    bit nreq;
    bit ngrant;
    if (!RESETn) begin
      m_rx = 0; m_tx = 0; m_req = 0; m_grant = 0;
      m_erx = 0; m_etx = 0; m_prev_en = 0;
      return;
    end
    fall = m_prev_en && !linkEnable;
    m_prev_en = linkEnable;
    if (fall) begin
      m_rx = 0; m_tx = 0; m_req = 0; m_grant = 0;
      m_erx = 0; m_etx = 0;
      return;
    end
    n = m_rx + (m_grant ? 8 : 0);
    m_erx = 0;
    if (gotNChar) begin
      if (m_rx == 0) m_erx = 1;
      else n = n - 1;
    end
    if (n > 56) begin
      m_erx = 1;
      n = 56;
    end
    t = m_tx;
    m_etx = 0;
    if (sentNChar) begin
      if (m_tx == 0) m_etx = 1;
      else t = t - 1;
    end
    if (gotFct) begin
      if (t + 8 <= 56) t = t + 8;
      else m_etx = 1;
    end
    if (!linkEnable) begin
      nreq = 0; ngrant = 0;
    end else if (m_req) begin
      nreq = !sendFctAck; ngrant = sendFctAck;
    end else begin
      ngrant = 0;
      nreq = !m_grant && (m_rx + 8 <= 56)
          && (int'(fifoFree) >= m_rx + 8) && !sendFctAck;
    end
    m_rx = n;
    m_tx = t;
    m_req = nreq;
    m_grant = ngrant;
  endtask

  always @(posedge CLOCK) begin
    #1;
    model_step();
    chk("sendFctReq", sendFctReq, m_req);
    chk("txCreditAvail", txCreditAvail, m_tx != 0);
    chk("creditErrRx", creditErrRx, m_erx);
    chk("creditErrTx", creditErrTx, m_etx);
  end

  task automatic nc();
    @(negedge CLOCK);
    gotNChar = 0;
    gotFct = 0;
    sentNChar = 0;
    sendFctAck = auto_ack && sendFctReq && !sendFctAck;
    if (sendFctAck) acks++;
  endtask

  task automatic cycles(input int k);
    repeat (k) nc();
  endtask

  task automatic do_reset();
    nc();
    RESETn = 0;
    nc();
    RESETn = 1;
  endtask

  initial begin
    int last_ack;
    RESETn = 0;
    nc();
    nc();
    chk("rst_req", sendFctReq, 0);
    chk("rst_avail", txCreditAvail, 0);
    chk("rst_erx", creditErrRx, 0);
    chk("rst_etx", creditErrTx, 0);
    RESETn = 1;

    // Startup: seven grants fill credit to 56.
    linkEnable = 1;
    fifoFree = 100;
    auto_ack = 1;
    acks = 0;
    cycles(60);
    chk("startup_acks", acks, 7);
    chk("startup_rx", m_rx, 56);
    chk("startup_noreq", sendFctReq, 0);

    // FIFO space gating.
    do_reset();
    fifoFree = 16;
    cycles(20);
    chk("gate_rx16", m_rx, 16);
    fifoFree = 20;
    cycles(5);
    chk("gate_20_noreq", sendFctReq, 0);
    fifoFree = 24;
    nc();
    chk("gate_24_req", sendFctReq, 1);
    cycles(5);

    // RX underflow.
    do_reset();
    fifoFree = 0;
    cycles(2);
    gotNChar = 1;
    nc();
    chk("rx_un_pulse", creditErrRx, 1);
    nc();
    chk("rx_un_once", creditErrRx, 0);
    chk("rx_un_cnt", m_rx, 0);

    // N-Char landing in the grant cycle at credit 5.
    fifoFree = 8;
    cycles(8);
    auto_ack = 0;
    repeat (3) begin
      gotNChar = 1;
      nc();
    end
    chk("sim_rx5", m_rx, 5);
    fifoFree = 100;
    nc();
    chk("sim_req", sendFctReq, 1);
    sendFctAck = 1;
    nc();
    gotNChar = 1;
    fifoFree = 19;
    nc();
    chk("sim_rx12", m_rx, 12);
    cycles(4);
    chk("sim_free19_noreq", sendFctReq, 0);
    fifoFree = 20;
    nc();
    chk("sim_free20_req", sendFctReq, 1);
    auto_ack = 1;
    cycles(4);

    // TX overflow, simultaneous events, underflow.
    do_reset();
    fifoFree = 0;
    repeat (7) begin
      gotFct = 1;
      nc();
    end
    repeat (6) begin
      sentNChar = 1;
      nc();
    end
    gotFct = 1;
    nc();
    chk("tx_ov_pulse", creditErrTx, 1);
    chk("tx_ov_cnt", m_tx, 50);
    nc();
    chk("tx_ov_once", creditErrTx, 0);
    repeat (47) begin
      sentNChar = 1;
      nc();
    end
    chk("tx_at3_avail", txCreditAvail, 1);
    gotFct = 1;
    sentNChar = 1;
    nc();
    chk("tx_both_cnt", m_tx, 10);
    chk("tx_both_avail", txCreditAvail, 1);
    repeat (10) begin
      sentNChar = 1;
      nc();
    end
    chk("tx_drained", txCreditAvail, 0);
    sentNChar = 1;
    nc();
    chk("tx_un_pulse", creditErrTx, 1);

    // Link drop mid-request, then a late acknowledge.
    auto_ack = 0;
    do_reset();
    fifoFree = 100;
    gotFct = 1;
    nc();
    chk("drop_req_up", sendFctReq, 1);
    linkEnable = 0;
    nc();
    chk("drop_req_low", sendFctReq, 0);
    chk("drop_avail", txCreditAvail, 0);
    sendFctAck = 1;
    nc();
    nc();
    chk("drop_rx0", m_rx, 0);
    chk("drop_noreq", sendFctReq, 0);
    linkEnable = 1;
    fifoFree = 0;
    cycles(2);

    // Random traffic.
    last_ack = 0;
    for (int i = 0; i < 3000; i++) begin
      nc();
      RESETn = ($urandom % 300) != 0;
      gotNChar = ($urandom % 4) == 0;
      gotFct = ($urandom % 6) == 0;
      sentNChar = ($urandom % 3) == 0;
      if (last_ack == 0 && sendFctReq && ($urandom % 3) == 0)
        sendFctAck = 1;
      else if (last_ack == 0 && ($urandom % 40) == 0)
        sendFctAck = 1;
      last_ack = sendFctAck;
      if (($urandom % 8) == 0) fifoFree = 8'($urandom_range(0, 80));
      if (linkEnable && ($urandom % 150) == 0) linkEnable = 0;
      else if (!linkEnable && ($urandom % 5) == 0) linkEnable = 1;
    end

    // Reset pulse mid-traffic.
    nc();
    RESETn = 1;
    linkEnable = 1;
    fifoFree = 100;
    auto_ack = 1;
    gotFct = 1;
    nc();
    gotFct = 1;
    cycles(3);
    RESETn = 0;
    gotNChar = 1;
    nc();
    chk("midrst_req", sendFctReq, 0);
    chk("midrst_avail", txCreditAvail, 0);
    chk("midrst_erx", creditErrRx, 0);
    chk("midrst_etx", creditErrTx, 0);
    RESETn = 1;
    cycles(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
